// File: rtl/remoper.sv
// Sign-magnitude remainder unit: registers sign(A) with |A| mod |B| one cycle after in_valid.
// The divisor sign is ignored; a zero divisor flags ZeroDiv and forces a zero magnitude.
module remoper #(
    parameter int MAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [MAG_W:0]   A,
    input  logic [MAG_W:0]   B,
    output logic             out_valid,
    output logic [MAG_W+2:0] R,
    output logic             ZeroDiv
);

    logic [MAG_W-1:0] magA;
    logic [MAG_W-1:0] magB;
    logic             signA;
    logic             unusedBSign;

    assign magA        = A[MAG_W-1:0];
    assign magB        = B[MAG_W-1:0];
    assign signA       = A[MAG_W];
    assign unusedBSign = B[MAG_W];

    // partRem[k] is the running remainder after k dividend bits (MSB first).
    // It is always below magB, so MAG_W bits suffice between stages.
    logic [MAG_W-1:0] partRem [0:MAG_W];

    assign partRem[0] = '0;

    genvar gi;
    generate
        for (gi = 0; gi < MAG_W; gi++) begin : g_stage
            logic [MAG_W:0]   shifted;
            logic [MAG_W-1:0] diff;
            logic             fits;

            assign shifted = {partRem[gi], magA[MAG_W-1-gi]};
            assign fits    = (shifted >= {1'b0, magB});
            // The difference is below magB whenever it is taken, so the low bits are exact.
            assign diff    = shifted[MAG_W-1:0] - magB;
            assign partRem[gi+1] = fits ? diff : shifted[MAG_W-1:0];
        end
    endgenerate

    logic             zeroDivNext;
    logic [MAG_W+2:0] rNext;

    always_comb begin
        zeroDivNext = (magB == '0);
        rNext       = '0;
        rNext[MAG_W+2] = signA;
        if (!zeroDivNext) begin
            rNext[MAG_W-1:0] = partRem[MAG_W];
        end
    end

    logic [MAG_W+2:0] rReg;
    logic             zeroDivReg;
    logic             outValidReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            rReg        <= '0;
            zeroDivReg  <= 1'b0;
            outValidReg <= 1'b0;
        end else begin
            outValidReg <= in_valid;
            if (in_valid) begin
                rReg       <= rNext;
                zeroDivReg <= zeroDivNext;
            end
        end
    end

    assign R         = rReg;
    assign ZeroDiv   = zeroDivReg;
    assign out_valid = outValidReg;

endmodule

// File: tb/tb_remoper.sv
// Self-checking bench for remoper (MAG_W=2): directed vectors, exhaustive sweep,
// random traffic with idle gaps, back-to-back issue and reset-over-valid.
module tb_remoper;

    localparam int MAG_W = 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic [MAG_W:0]   A;
    logic [MAG_W:0]   B;
    logic             out_valid;
    logic [MAG_W+2:0] R;
    logic             ZeroDiv;

    int checks;
    int errors;

    // Expected output state held by the reference model.
    logic [MAG_W+2:0] expR;
    logic             expZd;
    logic             expOv;

    remoper #(.MAG_W(MAG_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .out_valid(out_valid),
        .R        (R),
        .ZeroDiv  (ZeroDiv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural reference: plain integer modulo on magnitudes, sign from dividend.
    task automatic model(input logic r, input logic v, input logic [MAG_W:0] a, input logic [MAG_W:0] b);
        int magA;
        int magB;
        int rem;
        magA = int'(a) % (1 << MAG_W);
        magB = int'(b) % (1 << MAG_W);
        if (r) begin
            expR  = '0;
            expZd = 1'b0;
            expOv = 1'b0;
        end else begin
            expOv = v;
            if (v) begin
                rem   = (magB == 0) ? 0 : (magA % magB);
                expZd = (magB == 0);
                expR  = (a >= (1 << MAG_W)) ? (5'b10000 | 5'(rem)) : 5'(rem);
            end
        end
    endtask

    // Drive one cycle, let the edge happen, then compare 1 time unit later.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic [MAG_W:0] a, input logic [MAG_W:0] b);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
        model(r, v, a, b);
        $display("op %s rst=%0b v=%0b A=%b B=%b -> R=%b ZeroDiv=%0b out_valid=%0b",
                 tag, r, v, a, b, R, ZeroDiv, out_valid);
        chk({tag, ".R"}, 32'(R), 32'(expR));
        chk({tag, ".ZeroDiv"}, 32'(ZeroDiv), 32'(expZd));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(expOv));
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        expR     = '0;
        expZd    = 1'b0;
        expOv    = 1'b0;
        rst      = 1'b1;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        #2;

        // Reset state
        step("reset0", 1'b1, 1'b0, 3'b000, 3'b000);
        step("reset1", 1'b1, 1'b0, 3'b000, 3'b000);

        // Directed vectors with literal expectations
        step("d011_010", 1'b0, 1'b1, 3'b011, 3'b010);
        chk("d011_010.lit", 32'(R), 32'h01);
        step("d111_110", 1'b0, 1'b1, 3'b111, 3'b110);
        chk("d111_110.lit", 32'(R), 32'h11);
        step("d110_000", 1'b0, 1'b1, 3'b110, 3'b000);
        chk("d110_000.lit", 32'({R, ZeroDiv}), 32'b100001);
        step("d001_100", 1'b0, 1'b1, 3'b001, 3'b100);
        chk("d001_100.lit", 32'({R, ZeroDiv}), 32'b000001);
        step("d010_011", 1'b0, 1'b1, 3'b010, 3'b011);
        chk("d010_011.lit", 32'(R), 32'h02);
        step("d101_001", 1'b0, 1'b1, 3'b101, 3'b001);
        chk("d101_001.lit", 32'(R), 32'h10);
        step("d100_010", 1'b0, 1'b1, 3'b100, 3'b010);
        chk("d100_010.lit", 32'(R), 32'h10);

        // Exhaustive sweep of all 64 operand pairs
        for (int i = 0; i < 64; i++) begin
            step("sweep", 1'b0, 1'b1, 3'(i >> 3), 3'(i));
            chk("sweep.pad", 32'(R[3:2]), 32'd0);
        end

        // Random traffic with idle gaps (hold behaviour)
        for (int i = 0; i < 150; i++) begin
            step("rand", 1'b0, 1'($urandom_range(0, 1)), 3'($urandom), 3'($urandom));
        end

        // Back-to-back issue
        step("b2b0", 1'b0, 1'b1, 3'b011, 3'b010);
        chk("b2b0.lit", 32'({out_valid, R, ZeroDiv}), 32'b1000010);
        step("b2b1", 1'b0, 1'b1, 3'b110, 3'b000);
        chk("b2b1.lit", 32'({out_valid, R, ZeroDiv}), 32'b1100001);
        step("b2b2", 1'b0, 1'b1, 3'b111, 3'b011);
        chk("b2b2.lit", 32'({out_valid, R, ZeroDiv}), 32'b1100000);
        step("idle", 1'b0, 1'b0, 3'b001, 3'b001);
        chk("idle.hold", 32'({out_valid, R, ZeroDiv}), 32'b0100000);

        // Reset overrides a valid operation, then outputs hold zero
        step("rstv", 1'b1, 1'b1, 3'b011, 3'b010);
        chk("rstv.lit", 32'({out_valid, R, ZeroDiv}), 32'd0);
        step("post0", 1'b0, 1'b0, 3'b011, 3'b010);
        step("post1", 1'b0, 1'b0, 3'b111, 3'b001);
        chk("post1.lit", 32'({out_valid, R, ZeroDiv}), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
